// File: rtl/atari_pkg.sv
// Shared constants and types for the TIA-to-VGA line buffer.
//   H_PIXELS     : visible TIA pixels per scanline (bank depth)
//   COLOR_W      : TIA hue/luma code width
//   SCALE_SHIFT  : VGA x -> TIA pixel index shift (4x horizontal scale)
//   VGA_ACTIVE_W : VGA active width; positions at or beyond this read as blank
package atari_pkg;
  localparam int H_PIXELS     = 160;
  localparam int COLOR_W      = 7;
  localparam int SCALE_SHIFT  = 2;
  localparam int VGA_ACTIVE_W = 640;
  localparam int XPOS_W       = 8;

  typedef logic                bank_sel_t;
  typedef logic [COLOR_W-1:0]  color_t;
endpackage

// File: rtl/line_bank_ram.sv
// One scanline bank: H_PIXELS x COLOR_W, one write port, one registered read.
//   clk   : clock
//   we    : write enable (caller guarantees waddr < H_PIXELS)
//   waddr : write pixel index
//   wdata : write colour
//   raddr : read pixel index; out-of-range reads return 0
//   rdata : colour at raddr, one cycle later
// Contents are not reset.
module line_bank_ram
  import atari_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [XPOS_W-1:0] waddr,
  input  color_t            wdata,
  input  logic [XPOS_W-1:0] raddr,
  output color_t            rdata
);

  localparam logic [XPOS_W-1:0] DEPTH = XPOS_W'(H_PIXELS);

  color_t mem [H_PIXELS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (raddr < DEPTH) ? mem[raddr] : '0;
  end

endmodule

// File: rtl/tia_line_buffer.sv
// Ping-pong scanline store between the TIA pixel stream and VGA readout.
// TIA fills one bank while VGA replays the most recently completed line on
// two VGA lines at 4x horizontal scale. Also tracks TIA/VGA frame alignment.
//   clk, reset            : clock, synchronous active-high reset
//   tia_en/xpos/color     : TIA pixel strobe, index and colour
//   tia_vblank/tia_vsync  : TIA vertical blank / sync
//   vga_x/vga_y/vga_vsync : VGA raster position and vsync
//   pix_color/pix_blank   : colour and blank for vga_x, one cycle later
//   line_ready            : a completed line is held since reset
//   wait_vsync            : TIA frame ended, waiting for VGA vsync
//   overrun               : sticky, an unconsumed line was overwritten
module tia_line_buffer
  import atari_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tia_en,
  input  logic [XPOS_W-1:0] tia_xpos,
  input  color_t            tia_color,
  input  logic              tia_vblank,
  input  logic              tia_vsync,
  input  logic [9:0]        vga_x,
  input  logic [9:0]        vga_y,
  input  logic              vga_vsync,
  output color_t            pix_color,
  output logic              pix_blank,
  output logic              line_ready,
  output logic              wait_vsync,
  output logic              overrun
);

  localparam logic [XPOS_W-1:0] XLAST = XPOS_W'(H_PIXELS - 1);
  localparam logic [XPOS_W-1:0] XLIM  = XPOS_W'(H_PIXELS);
  localparam logic [9:0]        VGA_W = 10'(VGA_ACTIVE_W);

  bank_sel_t wr_bank, rd_bank, last_done, rd_nxt, sel_q;
  logic [1:0] bank_valid, bank_vblank, unconsumed;
  logic       line_end, rd_latch, wr_en, blank_nxt, blank_q, show_q, vsync_q;
  logic [XPOS_W-1:0]            rd_addr;
  logic [1:0][COLOR_W-1:0]      ram_q;
  logic                         unused_vga_y;

  assign unused_vga_y = ^vga_y[9:1];

  assign wr_en    = tia_en && (tia_xpos < XLIM);
  assign line_end = tia_en && (tia_xpos == XLAST);
  assign rd_latch = (vga_x == '0) && !vga_y[0];
  assign rd_addr  = vga_x[XPOS_W+SCALE_SHIFT-1:SCALE_SHIFT];

  // With only two banks, once a line completes the writer moves onto the
  // other bank; if the reader was parked there it is moved onto the bank
  // that just completed so it never reads the bank being refilled.
  always_comb begin
    rd_nxt = rd_bank;
    if (rd_latch) rd_nxt = last_done;
    if (line_end && (rd_nxt == ~wr_bank)) rd_nxt = wr_bank;
    blank_nxt = (vga_x >= VGA_W) || !bank_valid[rd_nxt] || bank_vblank[rd_nxt];
  end

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      line_bank_ram u_ram (
        .clk   (clk),
        .we    (wr_en && (wr_bank == 1'(b))),
        .waddr (tia_xpos),
        .wdata (tia_color),
        .raddr (rd_addr),
        .rdata (ram_q[b])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      last_done   <= 1'b1;
      bank_valid  <= '0;
      bank_vblank <= '0;
      unconsumed  <= '0;
      overrun     <= 1'b0;
      vsync_q     <= 1'b0;
      wait_vsync  <= 1'b0;
      blank_q     <= 1'b0;
      show_q      <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      rd_bank <= rd_nxt;
      if (rd_latch) unconsumed[last_done] <= 1'b0;
      if (line_end) begin
        bank_vblank[wr_bank] <= tia_vblank;
        bank_valid[wr_bank]  <= 1'b1;
        unconsumed[wr_bank]  <= 1'b1;
        if (unconsumed[wr_bank]) overrun <= 1'b1;
        last_done <= wr_bank;
        wr_bank   <= ~wr_bank;
      end
      // vga_vsync clear dominates a same-cycle TIA vsync fall
      vsync_q <= tia_vsync;
      if (vga_vsync)                   wait_vsync <= 1'b0;
      else if (vsync_q && !tia_vsync)  wait_vsync <= 1'b1;
      blank_q <= blank_nxt;
      show_q  <= !blank_nxt;
      sel_q   <= rd_nxt;
    end
  end

  // RAM read is the pipeline register; blank/select travel alongside it.
  assign pix_color  = show_q ? ram_q[sel_q] : '0;
  assign pix_blank  = blank_q;
  assign line_ready = |bank_valid;

endmodule
